// File: rtl/common_dffram_fifo_1w2r.sv
// common_dffram_fifo_1w2r: FIFO controller for an external 1W2R DFF RAM, presenting head and head+1 with 0/1/2 pops per cycle.
// Optional same-cycle bypass of an enqueue into an empty FIFO: COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN.
module common_dffram_fifo_1w2r #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  deq0_valid,
  output logic [DATA_WIDTH-1:0] deq0_data,
  output logic                  deq1_valid,
  output logic [DATA_WIDTH-1:0] deq1_data,
  input  logic                  deq_pop0,
  input  logic                  deq_pop1,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic [ADDR_WIDTH-1:0] ram_addrc,
  input  logic [DATA_WIDTH-1:0] ram_doutc
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] wr_ptr, rd_ptr, count, wr_inc, rd_inc;
  logic enq_fire, p0, p1, has0, has1, byp_pop;
  assign has0 = count != '0;
  assign has1 = count > PW'(1);
  assign enq_ready = (count != PW'(DEPTH)) & !reset;
`ifdef COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN
  logic byp;
  // An enqueue into an empty FIFO is visible at once; if consumed, the RAM never sees it.
  assign byp = !has0 & enq_valid & !flush & !reset;
  assign byp_pop = byp & deq_pop0;
  assign deq0_valid = has0 | byp;
  assign deq0_data = byp ? enq_data : ram_doutb;
`else
  assign byp_pop = 1'b0;
  assign deq0_valid = has0;
  assign deq0_data = ram_doutb;
`endif
  assign deq1_valid = has1;
  assign deq1_data = ram_doutc;
  assign enq_fire = enq_valid & enq_ready & !flush & !byp_pop;
  assign p0 = deq_pop0 & has0;
  assign p1 = p0 & deq_pop1 & has1;
  assign wr_inc = PW'(enq_fire);
  assign rd_inc = PW'(p0) + PW'(p1);
  assign level = count;
  assign ram_ena = enq_fire;
  assign ram_wea = enq_fire;
  assign ram_addra = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_dina = enq_data;
  assign ram_addrb = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_addrc = rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_inc;
      rd_ptr <= rd_ptr + rd_inc;
      count <= count + wr_inc - rd_inc;
    end
  end
endmodule

// File: tb/tb_common_dffram_fifo_1w2r.sv
// tb_common_dffram_fifo_1w2r: scoreboard bench for common_dffram_fifo_1w2r at DEPTH=4, DATA_WIDTH=8, with a behavioural 1W2R RAM.
module tb_common_dffram_fifo_1w2r;
`ifdef COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, enq_valid = 1'b0, deq_pop0 = 1'b0, deq_pop1 = 1'b0;
  logic [7:0] enq_data = '0;
  logic enq_ready, deq0_valid, deq1_valid, ram_ena, ram_wea;
  logic [7:0] deq0_data, deq1_data, ram_dina, ram_doutb, ram_doutc;
  logic [2:0] level;
  logic [1:0] ram_addra, ram_addrb, ram_addrc;
  logic [7:0] mem [4];
  logic [7:0] q [$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  common_dffram_fifo_1w2r #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_data(enq_data), .deq0_valid(deq0_valid), .deq0_data(deq0_data), .deq1_valid(deq1_valid),
    .deq1_data(deq1_data), .deq_pop0(deq_pop0), .deq_pop1(deq_pop1), .level(level),
    .ram_addra(ram_addra), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb), .ram_addrc(ram_addrc), .ram_doutc(ram_doutc)
  );

  always_ff @(posedge clk) if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
  assign ram_doutb = mem[ram_addrb];
  assign ram_doutc = mem[ram_addrc];

  task automatic tick();
    bit byp, fire, p0, p1;
    byp = BYP && q.size() == 0 && enq_valid && !flush && !reset && deq_pop0;
    fire = enq_valid && q.size() != 4 && !flush && !reset && !byp;
    p0 = deq_pop0 && q.size() >= 1;
    p1 = p0 && deq_pop1 && q.size() >= 2;
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (p0) void'(q.pop_front());
      if (p1) void'(q.pop_front());
      if (fire) q.push_back(enq_data);
    end
    #1;
  endtask

  task automatic idle();
    enq_valid = 0; deq_pop0 = 0; deq_pop1 = 0; flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; enq_valid = 1; enq_data = 8'hEE;
    tick(); tick();
    checks++; if (ram_ena !== 1'b0) begin errors++; $display("FAIL reset_ram_ena got %0b want 0", ram_ena); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL reset_enq_ready got %0b want 0", enq_ready); end
    reset = 0; idle(); #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", enq_ready); end
    checks++; if (deq0_valid !== 1'b0 || deq1_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b%0b want 00", deq0_valid, deq1_valid); end
  endtask

  task automatic test_fill();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1; enq_data = d[i]; #1;
      checks++; if (ram_ena !== 1'b1 || ram_addra !== 2'(i)) begin errors++; $display("FAIL fill_write%0d got ena=%0b addr=%0d want ena=1 addr=%0d", i, ram_ena, ram_addra, i); end
      tick();
    end
    idle(); #1;
    checks++; if (level !== 3'd4 || enq_ready !== 1'b0) begin errors++; $display("FAIL fill_full got level=%0d ready=%0b want 4 0", level, enq_ready); end
    checks++; if (deq0_valid !== 1'b1 || deq0_data !== 8'h11 || deq0_data !== q[0]) begin errors++; $display("FAIL fill_deq0 got %0b/%h want 1/11", deq0_valid, deq0_data); end
    checks++; if (deq1_valid !== 1'b1 || deq1_data !== 8'h22 || deq1_data !== q[1]) begin errors++; $display("FAIL fill_deq1 got %0b/%h want 1/22", deq1_valid, deq1_data); end
  endtask

  task automatic test_full_pop();
    enq_valid = 1; enq_data = 8'h99; deq_pop0 = 1; #1;
    checks++; if (enq_ready !== 1'b0 || ram_ena !== 1'b0) begin errors++; $display("FAIL full_pop_refuse got ready=%0b ena=%0b want 0 0", enq_ready, ram_ena); end
    tick(); idle(); #1;
    checks++; if (level !== 3'd3 || deq0_data !== 8'h22 || deq0_data !== q[0]) begin errors++; $display("FAIL full_pop_after got level=%0d deq0=%h want 3 22", level, deq0_data); end
  endtask

  task automatic test_pop_both();
    reset = 1; tick(); reset = 0;
    for (int i = 1; i <= 4; i++) begin enq_valid = 1; enq_data = 8'(i * 17); tick(); end
    idle(); deq_pop0 = 1; deq_pop1 = 1; tick(); #1;
    checks++; if (level !== 3'd2 || deq0_data !== 8'h33) begin errors++; $display("FAIL pop2_first got level=%0d deq0=%h want 2 33", level, deq0_data); end
    tick(); idle(); #1;
    checks++; if (level !== 3'd0 || deq0_valid !== 1'b0) begin errors++; $display("FAIL pop2_empty got level=%0d v0=%0b want 0 0", level, deq0_valid); end
    enq_valid = 1; enq_data = 8'h55; #1;
    checks++; if (ram_addra !== 2'd0) begin errors++; $display("FAIL wrap_addr55 got %0d want 0", ram_addra); end
    tick(); enq_data = 8'h66; #1;
    checks++; if (ram_addra !== 2'd1) begin errors++; $display("FAIL wrap_addr66 got %0d want 1", ram_addra); end
    tick(); idle(); #1;
    checks++; if (deq0_data !== 8'h55 || deq1_data !== 8'h66 || !deq0_valid || !deq1_valid) begin errors++; $display("FAIL wrap_data got %h/%h want 55/66", deq0_data, deq1_data); end
  endtask

  task automatic test_pop1_only();
    deq_pop0 = 1; tick(); idle();
    deq_pop1 = 1; tick(); #1;
    checks++; if (level !== 3'd1 || deq0_data !== 8'h66) begin errors++; $display("FAIL pop1_only got level=%0d deq0=%h want 1 66", level, deq0_data); end
    deq_pop0 = 1; tick(); idle(); #1;
    checks++; if (level !== 3'd0 || deq0_valid !== 1'b0) begin errors++; $display("FAIL pop_both_lvl1 got level=%0d want 0", level); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin enq_valid = 1; enq_data = 8'hA0 + 8'(i); tick(); end
    flush = 1; enq_data = 8'hBB; #1;
    checks++; if (ram_ena !== 1'b0 || level !== 3'd3) begin errors++; $display("FAIL flush_noena got ena=%0b level=%0d want 0 3", ram_ena, level); end
    tick(); idle(); #1;
    checks++; if (level !== 3'd0 || deq0_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got level=%0d v0=%0b want 0 0", level, deq0_valid); end
    enq_valid = 1; #1;
    checks++; if (ram_addra !== 2'd0) begin errors++; $display("FAIL flush_wrptr got %0d want 0", ram_addra); end
    idle();
  endtask

  task automatic test_bypass();
    enq_valid = 1; enq_data = 8'h77; deq_pop0 = 1; #1;
    checks++; if (deq0_valid !== BYP || ram_ena !== !BYP) begin errors++; $display("FAIL bypass_comb got v0=%0b ena=%0b want %0b %0b", deq0_valid, ram_ena, BYP, !BYP); end
    if (BYP) begin
      checks++; if (deq0_data !== 8'h77) begin errors++; $display("FAIL bypass_data got %h want 77", deq0_data); end
    end else begin
      checks++; if (ram_addra !== 2'd0) begin errors++; $display("FAIL bypass_addr got %0d want 0", ram_addra); end
    end
    tick(); idle(); #1;
    checks++; if (level !== (BYP ? 3'd0 : 3'd1)) begin errors++; $display("FAIL bypass_level got %0d want %0d", level, BYP ? 0 : 1); end
    deq_pop0 = 1; tick(); idle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      enq_valid = $urandom_range(0, 3) != 0; enq_data = 8'($urandom);
      deq_pop0 = $urandom_range(0, 1) == 1; deq_pop1 = $urandom_range(0, 1) == 1;
      flush = $urandom_range(0, 40) == 0; #1;
      checks++; if (level !== 3'(q.size()) || enq_ready !== (q.size() != 4)) begin errors++; $display("FAIL b2b_level c%0d got %0d/%0b want %0d", c, level, enq_ready, q.size()); end
      if (BYP && q.size() == 0 && enq_valid && !flush) begin
        checks++; if (deq0_valid !== 1'b1 || deq0_data !== enq_data) begin errors++; $display("FAIL b2b_byp c%0d got %0b/%h want 1/%h", c, deq0_valid, deq0_data, enq_data); end
      end else begin
        checks++; if (deq0_valid !== (q.size() >= 1) || (q.size() >= 1 && deq0_data !== q[0])) begin errors++; $display("FAIL b2b_deq0 c%0d got %0b/%h", c, deq0_valid, deq0_data); end
      end
      checks++; if (deq1_valid !== (q.size() >= 2) || (q.size() >= 2 && deq1_data !== q[1])) begin errors++; $display("FAIL b2b_deq1 c%0d got %0b/%h", c, deq1_valid, deq1_data); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_pop_both();
    test_pop1_only();
    test_flush();
    test_bypass();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/common_dffram_fifo_1w2r.md
Name: common_dffram_fifo_1w2r

Overview:
- FIFO controller that drives a 1-write/2-read DFF RAM (binary addressing, asynchronous read) through an external RAM port group.
- Accepts one enqueue per cycle and presents the two oldest entries, head and head+1, with pop of 0, 1 or 2 per cycle.
- Used in front of multi-issue consumers: decode/issue queues and store-buffer drain.

Parameters:
- DATA_WIDTH, 32, entry width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- ADDR_WIDTH (localparam), $clog2(DEPTH), RAM address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries at the next edge.
- enq_valid  input  1  enqueue request.
- enq_ready  output  1  enqueue accepted when high.
- enq_data  input  DATA_WIDTH  enqueue payload.
- deq0_valid  output  1  head entry present.
- deq0_data  output  DATA_WIDTH  head entry.
- deq1_valid  output  1  head+1 entry present.
- deq1_data  output  DATA_WIDTH  head+1 entry.
- deq_pop0  input  1  consume head.
- deq_pop1  input  1  consume head+1; honoured only together with deq_pop0.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- ram_addra  output  ADDR_WIDTH  RAM write address.
- ram_ena  output  1  RAM write port enable.
- ram_wea  output  1  RAM write enable.
- ram_dina  output  DATA_WIDTH  RAM write data.
- ram_addrb  output  ADDR_WIDTH  RAM read port B address (head).
- ram_doutb  input  DATA_WIDTH  RAM read port B data.
- ram_addrc  output  ADDR_WIDTH  RAM read port C address (head+1).
- ram_doutc  input  DATA_WIDTH  RAM read port C data.

Behaviour:
- State: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits (extra bit is the wrap bit), plus count (= level).
- Reset values: wr_ptr=0, rd_ptr=0, count=0. After reset: enq_ready=1, deq0_valid=0, deq1_valid=0, level=0.
- While reset is high: ram_ena=0 and ram_wea=0, and no pointer update other than clearing.
- enq_ready = (count != DEPTH) & !reset. It does not depend on pops in the same cycle, so a full FIFO with a simultaneous pop still refuses the enqueue.
- Write: when enq_fire = enq_valid & enq_ready & !flush, drive ram_ena=1, ram_wea=1, ram_addra=wr_ptr[ADDR_WIDTH-1:0], ram_dina=enq_data. Otherwise ram_ena=0 and ram_wea=0. wr_ptr increments by 1.
- Read addressing: ram_addrb=rd_ptr[ADDR_WIDTH-1:0]; ram_addrc=(rd_ptr+1) mod DEPTH. deq0_data=ram_doutb, deq1_data=ram_doutc; both combinational, zero latency.
- Valid flags: deq0_valid=(count>=1); deq1_valid=(count>=2).
- Effective pops:
  - p0 = deq_pop0 & deq0_valid.
  - p1 = p0 & deq_pop1 & deq1_valid.
  - deq_pop1 without deq_pop0 is ignored. Pops of invalid entries are ignored; no error is raised.
- Pointer/count update: rd_ptr += p0+p1; count_next = count + enq_fire - p0 - p1. Push and pop in the same cycle are both honoured.
- Wrap-around: pointers wrap modulo 2*DEPTH. full = (wr_ptr ^ rd_ptr) == {1'b1, zeros}; empty = (wr_ptr == rd_ptr). count must always equal wr_ptr - rd_ptr.
- Visibility: a newly enqueued entry becomes visible on deq0/deq1 no earlier than the cycle after enq_fire.
- Flush: at the next edge, rd_ptr=wr_ptr=0 and count=0. It suppresses the same-cycle enqueue (enq_ready may read high, but the write does not occur) and overrides pops.
- Reset has priority over flush.
- Reset mid-operation: all entries are lost; RAM contents are not cleared and are don't-care.

Optional Feature:
- Macro: COMMON_DFFRAM_FIFO_1W2R_BYPASS_EN.
- Defined:
  - When count==0 and enq_valid and !flush: deq0_valid=1 and deq0_data=enq_data in the same cycle.
  - If deq_pop0 is also high that cycle: no RAM write (ram_ena=0), pointers and count unchanged, enq_ready=1.
  - If not popped: normal write; the entry is served from the RAM from the next cycle.
  - deq1 is never bypassed.
- Undefined: zero-latency path absent; behaviour exactly as in Behaviour.

Test Plan (DEPTH=4, DATA_WIDTH=8):
- Reset, then enqueue 0x11, 0x22, 0x33, 0x44 on consecutive cycles → level=4, enq_ready=0; deq0_data=0x11 and deq1_data=0x22, both valid.
- Full FIFO, enq_valid=1 with pop0=1 same cycle → enqueue refused, level=3, deq0_data=0x22.
- Pop both (pop0=pop1=1) twice after filling 4 entries → level 4→2→0, deq0_valid=0; enqueue 0x55 then 0x66 → ram_addra=0 then 1 (wrap), deq0=0x55, deq1=0x66.
- level=1, pop1=1 with pop0=0 → no change, level=1; pop0=pop1=1 at level=1 → level=0 only.
- level=3, flush=1 with enq_valid=1 → next cycle level=0, deq0_valid=0, no RAM write that cycle (ram_ena=0).
- Empty, enq_valid=1 with data 0x77 and pop0=1 → with BYPASS_EN: deq0_valid=1, deq0_data=0x77, ram_ena=0, level stays 0; without BYPASS_EN: deq0_valid=0, write at addr 0, level=1.
